retire_rob: RTL and testbench
=============================

Name: retire_rob

Overview:
In-order retirement buffer (reorder buffer) for the speculative core. Allocates one tag per issued instruction and accepts out-of-order completions from the execution units. Retires entries in program order and drives the writeback port (wb_en/wb_addr/wb_out) into the decode-stage register map. Maintains the architectural (retired) register map and signals prediction_failed so decode can restore from it.

Parameters:
DEPTH, 8, number of ROB entries (power of two)
TAG_WIDTH, 3, log2(DEPTH)
ADDR_WIDTH, 15, instruction address width (32k ram)
DATA_WIDTH, 32, register width

Ports:
clk  in  1  core clock, rising edge
reset  in  1  asynchronous, active-low reset
alloc_valid_i  in  1  issue requests an entry this cycle
alloc_rd_i  in  5  destination register; 0 = no architectural write
alloc_addr_i  in  ADDR_WIDTH  instruction address (debug/redirect bookkeeping)
alloc_ready_o  out  1  entry available (registered, = !full)
alloc_tag_o  out  TAG_WIDTH  tag granted on alloc (= tail index)
complete_valid_i  in  1  execution unit result valid
complete_tag_i  in  TAG_WIDTH  tag of completing entry
complete_data_i  in  DATA_WIDTH  result value
complete_mispredict_i  in  1  entry is a branch whose speculated path was wrong
complete_target_i  in  ADDR_WIDTH  correct next address for a mispredicted branch
wb_en  out  1  architectural write this cycle
wb_addr  out  5  architectural destination
wb_out  out  DATA_WIDTH  architectural value
retired_regmap_o  out  1024  retired register file; reg ii at bits [1023-ii*32 -:32]
prediction_failed  out  1  one-cycle flush pulse
redirect_addr_o  out  ADDR_WIDTH+1  MSB = valid, low bits = restart address
count_o  out  TAG_WIDTH+1  occupied entries

Behaviour:
- Reset (reset=0, async): head=tail=0, all valid/done bits 0, count_o=0, alloc_ready_o=1, wb_en=0, wb_addr=0, wb_out=0, retired_regmap_o=0, prediction_failed=0, redirect_addr_o=0. Reset mid-operation discards all entries immediately.
- Pointers are TAG_WIDTH+1 bits (wrap bit); empty when equal, full when indices are equal and wrap bits differ. Wrap from DEPTH-1 to 0.
- Allocation: alloc_valid_i && alloc_ready_o at edge -> entry[tail] gets valid=1, done=0, rd, addr; tail+1. alloc_tag_o = tail index, combinational. alloc_valid_i while not ready is ignored. Full with a same-cycle retire: still not ready (no bypass).
- Completion: complete_valid_i with entry[tag].valid -> done=1, data, mispredict, target latched. Completion on an invalid entry is ignored. Rule: execution units drop in-flight results when prediction_failed=1.
- Retire: at most one per cycle. When entry[head].valid && done (registered state) -> retire at edge, head+1, valid=0. Minimum complete-to-retire latency is 1 cycle; outputs are visible the cycle after the retire edge.
- Retire outputs (registered, single-cycle): wb_en=1 iff rd!=0, with wb_addr=rd and wb_out=data; retired_regmap_o[rd] updated on the same edge. When no retire occurs, wb_en=0 and wb_addr/wb_out hold. Reg 0 stays 0.
- Mispredict retire: the entry's own write retires normally (JAL/JALR link). On the same edge, all entries are invalidated (tail=head+1 post-retire, i.e. empty) and any simultaneous alloc is discarded. prediction_failed=1 and redirect_addr_o={1,target} for exactly one cycle, then return to 0. Decode copies retired_regmap_o and then applies wb in that cycle, which is consistent because both already include the write.
- count_o = tail-head, updated each edge. Simultaneous alloc and retire leave count unchanged.

Decomposition:
- Shared package: DEPTH/TAG_WIDTH/ADDR_WIDTH/DATA_WIDTH constants, regmap packing/unpacking index function (1023-ii*32), opcode constant list shared with decode.
- Sub-module retire_regmap: 32x32 architectural register array with single write port and packed 1024-bit output; x0 forced to 0.

Test Plan:
- Reset then alloc rd=5, complete data=0x1234 one cycle later -> wb_en=1, wb_addr=5, wb_out=0x1234 two cycles after completion; retired_regmap_o[1023-5*32-:32]=0x1234.
- Alloc tags 0,1,2 (rd=1,2,3); complete in order 2,0,1 -> wb_addr sequence 1,2,3 on consecutive cycles; no retire before tag 0 is done.
- Fill 8 entries -> alloc_ready_o=0, count_o=8; a 9th alloc is ignored; retire one -> ready=1 the next cycle; tag wraps to 0.
- Alloc branch (rd=0) then 3 entries; complete all; branch mispredict target=0x40 -> prediction_failed=1 and redirect_addr_o=0x8040 for one cycle, wb_en=0, count_o=0, and the younger results are never written.
- Alloc rd=0 and complete it -> wb_en stays 0; retired_regmap_o reg0 = 0.
- Assert reset low mid-stream with 4 entries outstanding -> all outputs return to their reset values asynchronously; no wb_en after release.

Source files
------------

// File: rtl/retire_rob_pkg.sv
// Shared constants, types and helpers for the retirement buffer, its
// architectural register map, and the decode stage that consumes them.
package retire_rob_pkg;

  localparam int ROB_DEPTH      = 8;
  localparam int ROB_TAG_WIDTH  = $clog2(ROB_DEPTH);
  localparam int ROB_ADDR_WIDTH = 15;
  localparam int ROB_DATA_WIDTH = 32;
  localparam int NUM_ARCH_REGS  = 32;
  localparam int REGMAP_WIDTH   = NUM_ARCH_REGS * ROB_DATA_WIDTH;

  typedef logic [4:0] reg_idx_t;

  // Major opcodes, shared with decode so both sides agree on encodings.
  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011,
    OP_SYSTEM = 7'b1110011
  } opcode_e;

  // Most significant bit of register ii inside the packed register map.
  // Register 0 occupies the top word, register 31 the bottom word.
  function automatic int regmap_msb(input int ii);
    return REGMAP_WIDTH - 1 - ii * ROB_DATA_WIDTH;
  endfunction

endpackage

// File: rtl/retire_regmap.sv
// Architectural (retired) register file: one write port from retirement and
// a packed read-out of all 32 registers for decode-side flush recovery.
module retire_regmap
  import retire_rob_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      we,
  input  reg_idx_t                  waddr,
  input  logic [ROB_DATA_WIDTH-1:0] wdata,
  output logic [REGMAP_WIDTH-1:0]   regmap
);

  logic [ROB_DATA_WIDTH-1:0] regs [NUM_ARCH_REGS];

  // Register writes on retirement; x0 is never written so it stays 0.
  // NOTE: this array is reset (unlike plain storage) because the packed map
  // is architecturally visible and must read all-zero right after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int ii = 0; ii < NUM_ARCH_REGS; ii++) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // flop samples pre-edge values regardless of statement order.
        regs[ii] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  // Static packing of the register array into the flat map.
  for (genvar ii = 0; ii < NUM_ARCH_REGS; ii++) begin : g_pack
    assign regmap[regmap_msb(ii) -: ROB_DATA_WIDTH] = regs[ii];
  end

endmodule

// File: rtl/retire_rob.sv
// In-order retirement buffer: hands out tags at issue, collects out-of-order
// completions, retires the oldest finished entry each cycle, and flushes all
// younger work when a retiring branch turns out to be mispredicted.
module retire_rob
  import retire_rob_pkg::*;
#(
  parameter int DEPTH      = ROB_DEPTH,
  parameter int TAG_WIDTH  = ROB_TAG_WIDTH,
  parameter int ADDR_WIDTH = ROB_ADDR_WIDTH,
  parameter int DATA_WIDTH = ROB_DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    alloc_valid_i,
  input  reg_idx_t                alloc_rd_i,
  input  logic [ADDR_WIDTH-1:0]   alloc_addr_i,
  output logic                    alloc_ready_o,
  output logic [TAG_WIDTH-1:0]    alloc_tag_o,
  input  logic                    complete_valid_i,
  input  logic [TAG_WIDTH-1:0]    complete_tag_i,
  input  logic [DATA_WIDTH-1:0]   complete_data_i,
  input  logic                    complete_mispredict_i,
  input  logic [ADDR_WIDTH-1:0]   complete_target_i,
  output logic                    wb_en,
  output reg_idx_t                wb_addr,
  output logic [DATA_WIDTH-1:0]   wb_out,
  output logic [REGMAP_WIDTH-1:0] retired_regmap_o,
  output logic                    prediction_failed,
  output logic [ADDR_WIDTH:0]     redirect_addr_o,
  output logic [TAG_WIDTH:0]      count_o
);

  // Pointers carry one extra wrap bit to tell full from empty.
  typedef logic [TAG_WIDTH:0]   ptr_t;
  typedef logic [TAG_WIDTH-1:0] idx_t;

  ptr_t head_q, tail_q, head_nxt, tail_nxt;
  idx_t head_idx, tail_idx;

  logic [DEPTH-1:0] valid_q, valid_nxt;
  logic [DEPTH-1:0] done_q, done_nxt;
  logic [DEPTH-1:0] mispredict_q;

  reg_idx_t              rd_q     [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_q   [DEPTH];
  logic [DATA_WIDTH-1:0] data_q   [DEPTH];
  logic [ADDR_WIDTH-1:0] target_q [DEPTH];

  logic full;
  logic do_alloc;
  logic do_complete;
  logic do_retire;
  logic do_flush;
  logic head_writes;

  // Instruction address of the oldest entry; only observed in waveforms.
  logic [ADDR_WIDTH-1:0] unused_head_addr;

  assign head_idx = head_q[TAG_WIDTH-1:0];
  assign tail_idx = tail_q[TAG_WIDTH-1:0];

  assign full          = (head_idx == tail_idx) && (head_q[TAG_WIDTH] != tail_q[TAG_WIDTH]);
  assign alloc_ready_o = !full;
  assign alloc_tag_o   = tail_idx;
  assign count_o       = tail_q - head_q;

  // Retire decisions depend only on registered state, never on this
  // cycle's completion, so complete-to-retire is at least one cycle.
  assign do_retire   = valid_q[head_idx] && done_q[head_idx];
  assign do_flush    = do_retire && mispredict_q[head_idx];
  assign do_alloc    = alloc_valid_i && !full && !do_flush;
  assign do_complete = complete_valid_i && valid_q[complete_tag_i];
  assign head_writes = do_retire && (rd_q[head_idx] != '0);

  assign unused_head_addr = addr_q[head_idx];

  // Next-state for pointers and per-entry status bits.
  // NOTE: every variable gets its default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    valid_nxt = valid_q;
    done_nxt  = done_q;
    head_nxt  = head_q;
    tail_nxt  = tail_q;
    if (do_complete) begin
      done_nxt[complete_tag_i] = 1'b1;
    end
    if (do_retire) begin
      valid_nxt[head_idx] = 1'b0;
      head_nxt            = head_q + ptr_t'(1);
    end
    if (do_flush) begin
      // Everything younger than the mispredicted branch is discarded.
      valid_nxt = '0;
      tail_nxt  = head_q + ptr_t'(1);
    end else if (do_alloc) begin
      valid_nxt[tail_idx] = 1'b1;
      done_nxt[tail_idx]  = 1'b0;
      tail_nxt            = tail_q + ptr_t'(1);
    end
  end

  // Pointer and status registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      head_q  <= head_nxt;
      tail_q  <= tail_nxt;
      valid_q <= valid_nxt;
      done_q  <= done_nxt;
    end
  end

  // Entry payload; only meaningful while the valid bit is set, so no reset.
  always_ff @(posedge clk) begin
    if (do_alloc) begin
      rd_q[tail_idx]   <= alloc_rd_i;
      addr_q[tail_idx] <= alloc_addr_i;
    end
    if (do_complete) begin
      data_q[complete_tag_i]       <= complete_data_i;
      mispredict_q[complete_tag_i] <= complete_mispredict_i;
      target_q[complete_tag_i]     <= complete_target_i;
    end
  end

  // Registered writeback and flush outputs, each a single-cycle pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_en             <= 1'b0;
      wb_addr           <= '0;
      wb_out            <= '0;
      prediction_failed <= 1'b0;
      redirect_addr_o   <= '0;
    end else begin
      wb_en <= head_writes;
      if (head_writes) begin
        wb_addr <= rd_q[head_idx];
        wb_out  <= data_q[head_idx];
      end
      prediction_failed <= do_flush;
      redirect_addr_o   <= do_flush ? {1'b1, target_q[head_idx]} : '0;
    end
  end

  retire_regmap u_regmap (
    .clk    (clk),
    .reset  (reset),
    .we     (head_writes),
    .waddr  (rd_q[head_idx]),
    .wdata  (data_q[head_idx]),
    .regmap (retired_regmap_o)
  );

endmodule

// File: tb/tb_retire_rob.sv
// Self-checking bench for retire_rob: directed scenarios followed by random
// traffic, checked against a queue-based program-order model and a
// scoreboard of expected writeback/flush events.
module tb_retire_rob;
  import retire_rob_pkg::*;

  localparam int DEPTH = 8;
  localparam int TW    = 3;
  localparam int AW    = 15;
  localparam int DW    = 32;

  logic            clk;
  logic            reset;
  logic            alloc_valid_i;
  logic [4:0]      alloc_rd_i;
  logic [AW-1:0]   alloc_addr_i;
  logic            alloc_ready_o;
  logic [TW-1:0]   alloc_tag_o;
  logic            complete_valid_i;
  logic [TW-1:0]   complete_tag_i;
  logic [DW-1:0]   complete_data_i;
  logic            complete_mispredict_i;
  logic [AW-1:0]   complete_target_i;
  logic            wb_en;
  logic [4:0]      wb_addr;
  logic [DW-1:0]   wb_out;
  logic [1023:0]   retired_regmap_o;
  logic            prediction_failed;
  logic [AW:0]     redirect_addr_o;
  logic [TW:0]     count_o;

  retire_rob dut (
    .clk                   (clk),
    .reset                 (reset),
    .alloc_valid_i         (alloc_valid_i),
    .alloc_rd_i            (alloc_rd_i),
    .alloc_addr_i          (alloc_addr_i),
    .alloc_ready_o         (alloc_ready_o),
    .alloc_tag_o           (alloc_tag_o),
    .complete_valid_i      (complete_valid_i),
    .complete_tag_i        (complete_tag_i),
    .complete_data_i       (complete_data_i),
    .complete_mispredict_i (complete_mispredict_i),
    .complete_target_i     (complete_target_i),
    .wb_en                 (wb_en),
    .wb_addr               (wb_addr),
    .wb_out                (wb_out),
    .retired_regmap_o      (retired_regmap_o),
    .prediction_failed     (prediction_failed),
    .redirect_addr_o       (redirect_addr_o),
    .count_o               (count_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int errors = 0;
  int checks = 0;

  // Program-order model of in-flight instructions.
  typedef struct {
    logic [TW-1:0] tag;
    logic [4:0]    rd;
    logic [DW-1:0] data;
    bit            done;
    bit            mis;
    logic [AW-1:0] tgt;
  } ent_t;

  // One observable retirement: an architectural write and/or a flush.
  typedef struct {
    bit            wb;
    logic [4:0]    rd;
    logic [DW-1:0] data;
    bit            pf;
    logic [AW:0]   redir;
  } exp_t;

  ent_t          rob[$];
  exp_t          exp_q[$];
  int            next_tag;
  logic [DW-1:0] arch [32];
  bit            mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  // Compare the whole packed map against the model register file.
  task automatic check_regmap(input string name);
    int bad;
    bad = -1;
    checks++;
    for (int i = 0; i < 32; i++) begin
      if (bad < 0 && retired_regmap_o[1023 - i*32 -: 32] !== arch[i]) bad = i;
    end
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s: reg %0d got 0x%0h, expected 0x%0h", name, bad,
               retired_regmap_o[1023 - bad*32 -: 32], arch[bad]);
    end
  endtask

  task automatic model_reset();
    rob.delete();
    exp_q.delete();
    next_tag = 0;
    for (int i = 0; i < 32; i++) arch[i] = '0;
  endtask

  // Monitor: whenever the DUT shows a retirement event, pop and compare.
  initial begin
    exp_t ev;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (wb_en || prediction_failed) begin
          if (exp_q.size() == 0) begin
            check("unexpected_event", {62'd0, wb_en, prediction_failed}, 64'd0);
          end else begin
            ev = exp_q.pop_front();
            check("wb_en", wb_en, ev.wb);
            if (ev.wb) begin
              check("wb_addr", wb_addr, ev.rd);
              check("wb_out", wb_out, ev.data);
              check("regmap_rd", retired_regmap_o[regmap_msb(int'(ev.rd)) -: 32], ev.data);
            end
            check("prediction_failed", prediction_failed, ev.pf);
            check("redirect_addr", redirect_addr_o, ev.redir);
            if (ev.pf) check("count_after_flush", count_o, 0);
            check_regmap("regmap_event");
          end
        end else if (exp_q.size() != 0) begin
          check("missing_event", exp_q.size(), 0);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // One clock of stimulus; called at posedge+1 and returns at posedge+1.
  task automatic step(input bit av, input logic [4:0] ard, input bit cv,
                      input logic [TW-1:0] ctag, input logic [DW-1:0] cdata,
                      input bit cmis, input logic [AW-1:0] ctgt);
    int   pre_size;
    bit   flush;
    ent_t e;
    ent_t n;
    exp_t ev;
    alloc_valid_i         = av;
    alloc_rd_i            = ard;
    alloc_addr_i          = AW'($urandom);
    complete_valid_i      = cv;
    complete_tag_i        = ctag;
    complete_data_i       = cdata;
    complete_mispredict_i = cmis;
    complete_target_i     = ctgt;
    check("count", count_o, rob.size());
    check("alloc_ready", alloc_ready_o, rob.size() < DEPTH);
    check("alloc_tag", alloc_tag_o, next_tag);
    @(posedge clk);
    pre_size = rob.size();
    flush    = 1'b0;
    // Oldest entry retires if it finished in an earlier cycle.
    if (pre_size > 0 && rob[0].done) begin
      e = rob.pop_front();
      if (e.rd != 0) arch[e.rd] = e.data;
      if (e.rd != 0 || e.mis) begin
        ev.wb    = (e.rd != 0);
        ev.rd    = e.rd;
        ev.data  = e.data;
        ev.pf    = e.mis;
        ev.redir = e.mis ? {1'b1, e.tgt} : '0;
        exp_q.push_back(ev);
      end
      if (e.mis) begin
        rob.delete();
        next_tag = (int'(e.tag) + 1) % DEPTH;
        flush    = 1'b1;
      end
    end
    if (cv) begin
      foreach (rob[i]) begin
        if (rob[i].tag == ctag) begin
          rob[i].done = 1'b1;
          rob[i].data = cdata;
          rob[i].mis  = cmis;
          rob[i].tgt  = ctgt;
        end
      end
    end
    if (av && pre_size < DEPTH && !flush) begin
      n.tag  = TW'(next_tag);
      n.rd   = ard;
      n.data = '0;
      n.done = 1'b0;
      n.mis  = 1'b0;
      n.tgt  = '0;
      rob.push_back(n);
      next_tag = (next_tag + 1) % DEPTH;
    end
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 5'd0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic alloc(input logic [4:0] rd);
    step(1'b1, rd, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic complete(input logic [TW-1:0] tag, input logic [DW-1:0] data,
                          input bit mis, input logic [AW-1:0] tgt);
    step(1'b0, 5'd0, 1'b1, tag, data, mis, tgt);
  endtask

  // Complete outstanding work oldest-first until the model is empty.
  task automatic drain();
    int guard;
    guard = 0;
    while (rob.size() != 0 && guard < 64) begin
      bit            found;
      logic [TW-1:0] t;
      found = 1'b0;
      t     = '0;
      foreach (rob[i]) begin
        if (!found && !rob[i].done) begin
          found = 1'b1;
          t     = rob[i].tag;
        end
      end
      if (found) complete(t, DW'($urandom), 1'b0, '0);
      else idle(1);
      guard++;
    end
    idle(2);
    check("drain_count", count_o, 0);
  endtask

  task automatic rand_step();
    bit            av;
    bit            cv;
    bit            mis;
    logic [4:0]    rd;
    logic [TW-1:0] ctag;
    int            idx;
    av   = ($urandom_range(0, 9) < 6);
    rd   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    cv   = 1'b0;
    mis  = 1'b0;
    ctag = '0;
    if (rob.size() > 0 && $urandom_range(0, 9) < 7) begin
      idx = $urandom_range(0, rob.size() - 1);
      if (!rob[idx].done) begin
        cv   = 1'b1;
        ctag = rob[idx].tag;
        mis  = ($urandom_range(0, 15) == 0);
      end
    end else if (rob.size() < DEPTH && !prediction_failed && $urandom_range(0, 9) == 0) begin
      // Completion aimed at an unallocated slot must be ignored.
      cv   = 1'b1;
      ctag = TW'((next_tag + $urandom_range(0, DEPTH - 1 - rob.size())) % DEPTH);
    end
    step(av, rd, cv, ctag, DW'($urandom), mis, AW'($urandom));
  endtask

  initial begin
    int t;
    reset                 = 1'b0;
    alloc_valid_i         = 1'b0;
    alloc_rd_i            = '0;
    alloc_addr_i          = '0;
    complete_valid_i      = 1'b0;
    complete_tag_i        = '0;
    complete_data_i       = '0;
    complete_mispredict_i = 1'b0;
    complete_target_i     = '0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check("rst_count", count_o, 0);
    check("rst_ready", alloc_ready_o, 1);
    check("rst_wb_en", wb_en, 0);
    check("rst_wb_addr", wb_addr, 0);
    check("rst_wb_out", wb_out, 0);
    check("rst_pf", prediction_failed, 0);
    check("rst_redirect", redirect_addr_o, 0);
    check("rst_regmap", {63'd0, |retired_regmap_o}, 0);
    @(negedge clk);
    reset  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Single instruction: write appears two cycles after completion.
    alloc(5'd5);
    complete(3'd0, 32'h1234, 1'b0, '0);
    idle(1);
    check("single_wb_en", wb_en, 1);
    check("single_wb_addr", wb_addr, 5);
    check("single_wb_out", wb_out, 32'h1234);
    check("single_regmap", retired_regmap_o[1023 - 5*32 -: 32], 32'h1234);
    idle(1);
    check("single_wb_pulse", wb_en, 0);

    // Out-of-order completion retires in program order.
    alloc(5'd1);
    alloc(5'd2);
    alloc(5'd3);
    complete(3'd3, 32'hC0DE0003, 1'b0, '0);
    complete(3'd1, 32'hC0DE0001, 1'b0, '0);
    complete(3'd2, 32'hC0DE0002, 1'b0, '0);
    idle(4);

    // Destination x0 never writes and reg 0 stays zero.
    alloc(5'd0);
    complete(3'd4, 32'hDEADBEEF, 1'b0, '0);
    idle(3);
    check("x0_regmap", retired_regmap_o[1023 -: 32], 0);

    // Fill, overflow attempt, free one slot, tag wrap.
    for (int k = 0; k < DEPTH; k++) alloc(5'(10 + k));
    check("full_count", count_o, 8);
    check("full_ready", alloc_ready_o, 0);
    alloc(5'd30);
    check("full_ignored_count", count_o, 8);
    complete(rob[0].tag, 32'h5A5A0000, 1'b0, '0);
    idle(1);
    check("ready_after_retire", alloc_ready_o, 1);
    check("count_after_retire", count_o, 7);
    alloc(5'd18);
    drain();

    // Mispredicted branch flushes younger, already-finished work.
    t = next_tag;
    alloc(5'd0);
    alloc(5'd7);
    alloc(5'd8);
    alloc(5'd9);
    complete(TW'(t + 1), 32'hAAAA0001, 1'b0, '0);
    complete(TW'(t + 2), 32'hAAAA0002, 1'b0, '0);
    complete(TW'(t + 3), 32'hAAAA0003, 1'b0, '0);
    complete(TW'(t), 32'h0, 1'b1, 15'h0040);
    step(1'b1, 5'd11, 1'b0, '0, '0, 1'b0, '0);
    check("flush_pf", prediction_failed, 1);
    check("flush_redirect", redirect_addr_o, 16'h8040);
    check("flush_wb_en", wb_en, 0);
    check("flush_count", count_o, 0);
    idle(1);
    check("flush_pf_pulse", prediction_failed, 0);
    check("flush_redirect_clear", redirect_addr_o, 0);
    idle(3);
    check("young_not_written", retired_regmap_o[regmap_msb(7) -: 32], 0);
    check_regmap("after_flush");

    // Asynchronous reset with work outstanding.
    alloc(5'd20);
    alloc(5'd21);
    alloc(5'd22);
    alloc(5'd23);
    complete(rob[2].tag, 32'h11111111, 1'b0, '0);
    complete(rob[3].tag, 32'h22222222, 1'b0, '0);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("arst_count", count_o, 0);
    check("arst_ready", alloc_ready_o, 1);
    check("arst_tag", alloc_tag_o, 0);
    check("arst_wb_en", wb_en, 0);
    check("arst_pf", prediction_failed, 0);
    check("arst_redirect", redirect_addr_o, 0);
    check("arst_regmap", {63'd0, |retired_regmap_o}, 0);
    model_reset();
    alloc_valid_i    = 1'b0;
    complete_valid_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    idle(5);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) rand_step();
    drain();
    idle(4);
    check("scoreboard_empty", exp_q.size(), 0);
    check_regmap("final_regmap");

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
